// File: rtl/branch_cmp_iter.sv
// Iterative RV32I branch comparator: compares A and B CHUNK bits per cycle, MSB chunk first,
// and exits early on the first chunk that differs.
module branch_cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             BrEq,
  output logic             BrLT,
  output logic             taken,
  output logic             illegal
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // CMP   | comparing one chunk per cycle, MSB chunk first
  // DONE  | result held until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_BIT  = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("branch_cmp_iter: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f3_q;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             chunk_eq;
  logic             chunk_lt;

  function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'b000:         taken_of = eq;
      3'b001:         taken_of = !eq;
      3'b100, 3'b110: taken_of = lt;
      3'b101, 3'b111: taken_of = !lt;
      default:        taken_of = 1'b0;
    endcase
  endfunction

  // Operands shift left each step, so the chunk under test (index idx) is always the top chunk.
  assign chunk_a  = a_q[WIDTH-1 -: CHUNK];
  assign chunk_b  = b_q[WIDTH-1 -: CHUNK];
  assign chunk_eq = (chunk_a == chunk_b);
  assign chunk_lt = (chunk_a < chunk_b);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      idx     <= '0;
      BrEq    <= 1'b0;
      BrLT    <= 1'b0;
      taken   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
            a_q   <= funct3[1] ? A : (A ^ MSB_BIT);
            b_q   <= funct3[1] ? B : (B ^ MSB_BIT);
            f3_q  <= funct3;
            idx   <= IDX_LAST;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          if (!chunk_eq) begin
            BrEq    <= 1'b0;
            BrLT    <= chunk_lt;
            taken   <= taken_of(f3_q, 1'b0, chunk_lt);
            illegal <= (f3_q[2:1] == 2'b01);
            state   <= S_DONE;
          end else if (idx == '0) begin
            BrEq    <= 1'b1;
            BrLT    <= 1'b0;
            taken   <= taken_of(f3_q, 1'b1, 1'b0);
            illegal <= (f3_q[2:1] == 2'b01);
            state   <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
            a_q <= a_q << CHUNK;
            b_q <= b_q << CHUNK;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cmp_iter.sv
// Bench for branch_cmp_iter: four parameter sets side by side, directed cases then random sweep,
// each result checked against an arithmetic reference model.
module tb_branch_cmp_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a_drv = '0;
  logic [63:0] b_drv = '0;
  logic [2:0]  f3_drv = '0;
  logic        or_drv = 1'b0;
  logic [3:0]  iv = '0;
  logic [3:0]  ir, ov, eq, lt, tk, il;

  int cmp_n = 0;
  int err_n = 0;

  localparam int WID [4] = '{32, 32, 64, 16};
  localparam int CHK [4] = '{8, 32, 16, 1};

  always #5 clk = ~clk;

  branch_cmp_iter #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(a_drv[31:0]), .B(b_drv[31:0]),
    .funct3(f3_drv), .out_valid(ov[0]), .out_ready(or_drv), .BrEq(eq[0]), .BrLT(lt[0]),
    .taken(tk[0]), .illegal(il[0]));
  branch_cmp_iter #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(a_drv[31:0]), .B(b_drv[31:0]),
    .funct3(f3_drv), .out_valid(ov[1]), .out_ready(or_drv), .BrEq(eq[1]), .BrLT(lt[1]),
    .taken(tk[1]), .illegal(il[1]));
  branch_cmp_iter #(.WIDTH(64), .CHUNK(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(a_drv), .B(b_drv),
    .funct3(f3_drv), .out_valid(ov[2]), .out_ready(or_drv), .BrEq(eq[2]), .BrLT(lt[2]),
    .taken(tk[2]), .illegal(il[2]));
  branch_cmp_iter #(.WIDTH(16), .CHUNK(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .A(a_drv[15:0]), .B(b_drv[15:0]),
    .funct3(f3_drv), .out_valid(ov[3]), .out_ready(or_drv), .BrEq(eq[3]), .BrLT(lt[3]),
    .taken(tk[3]), .illegal(il[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    cmp_n++;
    assert (obs === expv) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain arithmetic on the whole operands; k comes from the highest differing bit.
  task automatic ref_model(input int w, input int c, input logic [63:0] a_in, input logic [63:0] b_in,
                           input logic [2:0] f3, output logic e_eq, output logic e_lt,
                           output logic e_tk, output logic e_il, output int e_k);
    logic [63:0] mask, a, b, x;
    longint sa, sb;
    int p;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    e_eq = (a == b);
    if (!f3[1]) begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
      e_lt = (sa < sb);
    end else begin
      e_lt = (a < b);
    end
    x = a ^ b;
    p = -1;
    for (int i = 0; i < 64; i++) if (x[i]) p = i;
    e_k = (p < 0) ? (w / c) : (w / c - p / c);
    e_il = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000: e_tk = e_eq;
      3'b001: e_tk = !e_eq;
      3'b100, 3'b110: e_tk = e_lt;
      3'b101, 3'b111: e_tk = !e_lt;
      default: e_tk = 1'b0;
    endcase
  endtask

  task automatic run_one(input int sel, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] f3, input int hold);
    logic e_eq, e_lt, e_tk, e_il;
    int e_k, k, n;
    n = WID[sel] / CHK[sel];
    ref_model(WID[sel], CHK[sel], a, b, f3, e_eq, e_lt, e_tk, e_il, e_k);
    @(negedge clk);
    check("in_ready_idle", ir[sel], 1'b1);
    a_drv = a; b_drv = b; f3_drv = f3; iv[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0;
    a_drv = {$urandom, $urandom}; b_drv = {$urandom, $urandom}; f3_drv = 3'($urandom);
    k = 0;
    while (!ov[sel] && k <= n + 2) begin
      @(posedge clk); k++; @(negedge clk);
    end
    check("latency", 64'(k), 64'(e_k));
    check("k_range", 64'(k >= 1 && k <= n), 64'd1);
    if (!ov[sel]) begin
      rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
      return;
    end
    check("BrEq", eq[sel], e_eq);
    check("BrLT", lt[sel], e_lt);
    check("taken", tk[sel], e_tk);
    check("illegal", il[sel], e_il);
    check("in_ready_busy", ir[sel], 1'b0);
    for (int h = 0; h < hold; h++) begin
      iv[sel] = 1'b1;
      a_drv = {$urandom, $urandom}; b_drv = {$urandom, $urandom}; f3_drv = 3'($urandom);
      @(posedge clk); @(negedge clk);
      check("hold_valid", ov[sel], 1'b1);
      check("hold_ready", ir[sel], 1'b0);
      check("hold_out", {eq[sel], lt[sel], tk[sel], il[sel]}, {e_eq, e_lt, e_tk, e_il});
    end
    iv[sel] = 1'b0;
    or_drv = 1'b1;
    @(posedge clk); @(negedge clk);
    or_drv = 1'b0;
    check("after_hs_valid", ov[sel], 1'b0);
    check("after_hs_ready", ir[sel], 1'b1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int bit_n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ir, 4'hF);
    check("rst_valid", ov, 4'h0);
    check("rst_outs", {eq, lt, tk, il}, 16'h0);
    rst = 1'b0;

    run_one(0, 64'h12345678, 64'h12345678, 3'b000, 0);
    run_one(0, 64'hFFFFFFFF, 64'h00000001, 3'b100, 0);
    run_one(0, 64'hFFFFFFFF, 64'h00000001, 3'b110, 0);
    run_one(0, 64'h000000FF, 64'h00000100, 3'b111, 0);
    run_one(0, 64'h80000000, 64'h7FFFFFFF, 3'b101, 5);
    run_one(0, 64'h00001234, 64'h00005678, 3'b010, 0);
    run_one(0, 64'h00001234, 64'h00001234, 3'b011, 0);

    // Reset during the second CMP cycle must drop the request.
    @(negedge clk);
    a_drv = 64'h12345678; b_drv = 64'h12345678; f3_drv = 3'b000; iv[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", ov[0], 1'b0);
    check("midrst_ready", ir[0], 1'b1);
    check("midrst_eq", eq[0], 1'b0);
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      check("midrst_no_result", ov[0], 1'b0);
    end
    run_one(0, 64'h00000005, 64'h00000003, 3'b001, 1);

    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < 30; t++) begin
        ra = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: rb = {$urandom, $urandom};
          1: rb = ra;
          2: begin
            bit_n = $urandom_range(0, WID[s] - 1);
            rb = ra ^ (64'd1 << bit_n);
          end
          default: rb = ra ^ (64'd1 << (WID[s] - 1));
        endcase
        run_one(s, ra, rb, 3'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
